// File: rtl/wwdg_pkg.sv
// Shared constants for the multi-channel window watchdog: keys, register
// offsets, status bit positions and the prescaler sizing helper.
package wwdg_pkg;

  localparam logic [15:0] KEY_START  = 16'hCCCC;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
  localparam logic [15:0] KEY_UNLOCK = 16'h5555;

  localparam logic [3:0] OFF_KR  = 4'h0;
  localparam logic [3:0] OFF_PR  = 4'h4;
  localparam logic [3:0] OFF_RLR = 4'h8;
  localparam logic [3:0] OFF_WR  = 4'hC;

  typedef enum logic [1:0] {
    REG_KR,
    REG_PR,
    REG_RLR,
    REG_WR
  } reg_sel_e;

  localparam int ST_RUN      = 0;
  localparam int ST_EWF      = 1;
  localparam int ST_WVF      = 2;
  localparam int ST_TOF      = 3;
  localparam int ST_UNLOCKED = 4;

  localparam int W1C_BIT   = 15;
  localparam int EWIE_BIT  = 15;
  localparam int PSC_WIDTH = 9;

  // Terminal prescaler count for a period of 2^(pr+2) clocks.
  function automatic logic [PSC_WIDTH-1:0] psc_limit(input logic [2:0] pr);
    logic [PSC_WIDTH:0] span;
    logic [PSC_WIDTH:0] lim;
    span = {{(PSC_WIDTH-2){1'b0}}, 3'b100} << pr;
    lim  = span - {{PSC_WIDTH{1'b0}}, 1'b1};
    return lim[PSC_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/wwdg_channel.sv
// One independent watchdog channel: key/lock handling, prescaler, down-counter,
// window check and status flags.
module wwdg_channel
  import wwdg_pkg::*;
#(
  parameter int CNT_WIDTH = 12,
  parameter int DAT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  reg_sel_e             sel,
  input  logic [DAT_WIDTH-1:0] wr_data,
  output logic [DAT_WIDTH-1:0] rd_data,
  output logic                 wdg_rst,
  output logic                 irq
);

  localparam logic [DAT_WIDTH-1:0] K_START  = DAT_WIDTH'(KEY_START);
  localparam logic [DAT_WIDTH-1:0] K_RELOAD = DAT_WIDTH'(KEY_RELOAD);
  localparam logic [DAT_WIDTH-1:0] K_UNLOCK = DAT_WIDTH'(KEY_UNLOCK);

  logic                 run, ewf, wvf, tof, unlocked;
  logic [2:0]           pr;
  logic [CNT_WIDTH-1:0] rlr, cnt;
  logic [DAT_WIDTH-1:0] wr;
  logic [PSC_WIDTH-1:0] psc;

  logic kr_wr, key_start, key_reload, key_unlock;
  logic pr_wr, pr_w1c, rlr_wr, wr_wr;
  logic tick, restart, win_viol, timeout, ewarn;

  assign kr_wr      = wr_en && (sel == REG_KR);
  assign key_start  = kr_wr && (wr_data == K_START);
  assign key_reload = kr_wr && (wr_data == K_RELOAD);
  assign key_unlock = kr_wr && (wr_data == K_UNLOCK);

  // Bit 15 of a PR write turns it into a flag-clear that bypasses the lock.
  assign pr_w1c = wr_en && (sel == REG_PR) && wr_data[W1C_BIT];
  assign pr_wr  = wr_en && unlocked && (sel == REG_PR) && !wr_data[W1C_BIT];
  assign rlr_wr = wr_en && unlocked && (sel == REG_RLR);
  assign wr_wr  = wr_en && unlocked && (sel == REG_WR);

  assign tick     = run && (psc == psc_limit(pr));
  assign restart  = key_start || key_reload;
  assign win_viol = key_reload && run && (cnt > wr[CNT_WIDTH-1:0]);
  assign timeout  = tick && (cnt == '0) && !restart;
  assign ewarn    = tick && (cnt == CNT_WIDTH'(2)) && !restart;

  assign irq = ewf && wr[EWIE_BIT];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      ewf      <= 1'b0;
      wvf      <= 1'b0;
      tof      <= 1'b0;
      unlocked <= 1'b0;
      pr       <= '0;
      rlr      <= '1;
      wr       <= '1;
      cnt      <= '1;
      psc      <= '0;
      wdg_rst  <= 1'b0;
    end else begin
      wdg_rst <= win_viol || timeout;

      if (key_unlock)      unlocked <= 1'b1;
      else if (kr_wr)      unlocked <= 1'b0;
      if (key_start)       run <= 1'b1;
      if (pr_wr)           pr  <= wr_data[2:0];
      if (rlr_wr)          rlr <= wr_data[CNT_WIDTH-1:0];
      if (wr_wr)           wr  <= wr_data;

      if (restart || timeout) cnt <= rlr;
      else if (tick)          cnt <= cnt - 1'b1;

      if (restart || pr_wr || tick || !run) psc <= '0;
      else                                  psc <= psc + 1'b1;

      // A timeout opens a fresh period, so a stale early warning is dropped.
      if (key_reload || timeout) ewf <= 1'b0;
      else if (ewarn)            ewf <= 1'b1;

      if (win_viol)                        wvf <= 1'b1;
      else if (pr_w1c && wr_data[ST_WVF])  wvf <= 1'b0;
      if (timeout)                         tof <= 1'b1;
      else if (pr_w1c && wr_data[ST_TOF])  tof <= 1'b0;
    end
  end

  // NOTE: rd_data gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    case (sel)
      REG_KR: begin
        rd_data[ST_RUN]      = run;
        rd_data[ST_EWF]      = ewf;
        rd_data[ST_WVF]      = wvf;
        rd_data[ST_TOF]      = tof;
        rd_data[ST_UNLOCKED] = unlocked;
      end
      REG_PR:  rd_data[2:0]           = pr;
      REG_RLR: rd_data[CNT_WIDTH-1:0] = rlr;
      REG_WR:  rd_data                = wr;
      default: rd_data                = '0;
    endcase
  end

endmodule

// File: rtl/wwdg_multi.sv
// Multi-channel window watchdog with a Wishbone register interface; decodes the
// bus, acknowledges every access and fans writes out to the channels.
module wwdg_multi
  import wwdg_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_WIDTH = 12,
  parameter int          DAT_WIDTH = 16,
  parameter logic [31:0] BASE_ADR  = 32'h0100_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DAT_WIDTH-1:0] dat_m2s,
  input  logic [31:0]          adr_m2s,
  input  logic                 cyc_m2s,
  input  logic                 stb_m2s,
  input  logic                 we_m2s,
  output logic [DAT_WIDTH-1:0] dat_s2m,
  output logic                 ack_s2m,
  output logic [NUM_CH-1:0]    wdg_rst,
  output logic [NUM_CH-1:0]    irq
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [31:0]          rel;
  logic                 req, in_range, reg_hit, hit;
  logic [CH_W-1:0]      ch;
  reg_sel_e             sel;
  logic [NUM_CH-1:0]    ch_wr;
  logic [DAT_WIDTH-1:0] ch_rd [NUM_CH];
  logic [DAT_WIDTH-1:0] rd_sel_data;

  // Addresses below the base wrap to large offsets and fall out of range.
  assign rel      = adr_m2s - BASE_ADR;
  assign in_range = rel < 32'(NUM_CH * 16);
  assign ch       = rel[4 +: CH_W];
  assign req      = cyc_m2s && stb_m2s && !ack_s2m;
  assign hit      = in_range && reg_hit;

  always_comb begin
    sel     = REG_KR;
    reg_hit = 1'b1;
    case (rel[3:0])
      OFF_KR:  sel = REG_KR;
      OFF_PR:  sel = REG_PR;
      OFF_RLR: sel = REG_RLR;
      OFF_WR:  sel = REG_WR;
      default: reg_hit = 1'b0;
    endcase
  end

  always_comb begin
    rd_sel_data = '0;
    ch_wr       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit && (ch == CH_W'(c))) begin
        rd_sel_data = ch_rd[c];
        ch_wr[c]    = req && we_m2s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_s2m <= 1'b0;
      dat_s2m <= '0;
    end else begin
      ack_s2m <= req;
      dat_s2m <= (req && !we_m2s && hit) ? rd_sel_data : '0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wwdg_channel #(
      .CNT_WIDTH(CNT_WIDTH),
      .DAT_WIDTH(DAT_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ch_wr[c]),
      .sel     (sel),
      .wr_data (dat_m2s),
      .rd_data (ch_rd[c]),
      .wdg_rst (wdg_rst[c]),
      .irq     (irq[c])
    );
  end

endmodule
